ext_pipe: RTL and testbench
===========================

// Module: ext_pipe
// PURPOSE
//  Parametrised, registered immediate extender with valid/ready handshake.
//  Sits between instruction-register decode and the ALU-B / PC-offset mux of the multicycle datapath.
//  Adds a two-beat CAT mode that assembles a 2*IMM_W constant from consecutive immediates (LUI+ORI fusion).
// PARAMETERS
//  IMM_W   16  input immediate width
//  DATA_W  32  output width; must satisfy DATA_W >= 2*IMM_W (elaboration error otherwise)
// PORTS
//  clk        in   1       rising-edge clock, the only clock
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       synchronous abort: drop pending CAT half and output word
//  in_valid   in   1       imm/ext_op valid
//  in_ready   out  1       beat accepted when in_valid && in_ready
//  imm        in   IMM_W   immediate to extend
//  ext_op     in   OP_W    0=ZERO 1=SIGN 2=HIGH 3=CAT (+4=SIGN_SHL2 with EXT_SHL2_EN); OP_W=2, or 3 with macro
//  out_valid  out  1       out_data valid
//  out_ready  in   1       consumer accepts when out_valid && out_ready
//  out_data   out  DATA_W  extended result
//  cat_busy   out  1       high while a CAT upper half is held
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, out_data=0, cat_busy=0, FSM=IDLE, hi_reg=0. in_ready=0 during reset.
//  in_ready = !rst && !flush && (!out_valid || out_ready)  (single output stage, full throughput).
//  Latency: accepted beat producing a result -> out_valid=1 on next edge; out_data held stable until taken.
//  Arithmetic (L = DATA_W-IMM_W):
//   ZERO: {L'b0, imm}            SIGN: {{L{imm[IMM_W-1]}}, imm}
//   HIGH: imm << L  ({imm, L'b0}) undefined op codes: treated as ZERO
//  CAT FSM, states IDLE / HI_HELD:
//   IDLE: accepted beat with op=CAT -> hi_reg<=imm, go HI_HELD, cat_busy=1, NO output produced.
//   IDLE: any other op -> normal result, stay IDLE.
//   HI_HELD: next accepted beat, regardless of ext_op, is the low half ->
//     out_data = zero-extend({hi_reg, imm}) to DATA_W, go IDLE, cat_busy=0.
//   HI_HELD holds indefinitely while in_valid=0; no timeout.
//  Output register: loads when a result-producing beat is accepted; out_valid clears when taken with no new result.
//   Accept-and-take in the same cycle: new word replaces old, out_valid stays 1.
//  flush (sync, highest priority after rst): next edge out_valid=0, FSM=IDLE, cat_busy=0;
//   concurrent input beat is not accepted (in_ready=0) and concurrent output take is void.
//  rst asserted mid-CAT or with out_valid=1: everything cleared immediately, no partial result ever emitted.
//  out_data holds its last value when out_valid=0; out_data is not cleared by flush.
// CONFIGURATION
//  EXT_SHL2_EN defined: OP_W=3, op 4 = SIGN_SHL2 -> (SIGN result) << 2, upper bits discarded (branch offsets);
//   ops 5-7 treated as ZERO. In HI_HELD the op is still ignored.
//  EXT_SHL2_EN undefined: OP_W=2, only ops 0-3 exist; branch scaling is done downstream.
// TESTING (IMM_W=16, DATA_W=32)
//  reset then SIGN imm=16'h8001, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001.
//  ZERO 16'h8001, HIGH 16'h1234 back-to-back, out_ready=1 -> 32'h00008001 then 32'h12340000, in_ready stays 1.
//  CAT 16'hDEAD, idle 3 cycles, then SIGN 16'hBEEF -> cat_busy=1 for 4 cycles, single output 32'hDEADBEEF.
//  out_ready=0 with out_valid=1 -> in_ready=0, out_data stable 5 cycles; release -> word taken once, no loss.
//  CAT 16'hAAAA, then flush with in_valid=1 -> cat_busy=0, out_valid=0; following ZERO 16'h0005 -> 32'h00000005.
//  EXT_SHL2_EN: op 4, imm=16'hFFFF -> 32'hFFFFFFFC; rst pulse during HI_HELD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ext_pipe.sv
// Registered immediate extender (ZERO/SIGN/HIGH, two-beat CAT) with valid/ready on both sides.
// Latency: one cycle from an accepted result-producing beat to out_valid; a CAT upper half produces no output.
// Backpressure: in_ready = !rst && !flush && (!out_valid || out_ready); out_data is held stable until taken.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flush                synchronous abort of the pending CAT half and the output word
//   in_valid/in_ready    input handshake for imm + ext_op
//   imm [IMM_W-1:0]      immediate to extend
//   ext_op [OP_W-1:0]    0=ZERO 1=SIGN 2=HIGH 3=CAT (4=SIGN_SHL2 when EXT_SHL2_EN is defined)
//   out_valid/out_ready  output handshake
//   out_data [DATA_W-1:0] extended result
//   cat_busy             high while a CAT upper half is held
//
// Build option: define EXT_SHL2_EN to widen ext_op to 3 bits and add SIGN_SHL2
// (sign-extend then shift left by 2, for branch offsets). Ops 5-7 then behave as ZERO.

module ext_pipe #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IMM_W-1:0]    imm,
`ifdef EXT_SHL2_EN
   input  logic [2:0]          ext_op,
`else
   input  logic [1:0]          ext_op,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                cat_busy
);

`ifdef EXT_SHL2_EN
   localparam int OP_W = 3;
`else
   localparam int OP_W = 2;
`endif

   localparam int L = DATA_W - IMM_W;

   localparam logic [OP_W-1:0] OP_ZERO = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SIGN = OP_W'(1);
   localparam logic [OP_W-1:0] OP_HIGH = OP_W'(2);
   localparam logic [OP_W-1:0] OP_CAT  = OP_W'(3);
`ifdef EXT_SHL2_EN
   localparam logic [OP_W-1:0] OP_SHL2 = OP_W'(4);
`endif

   generate
      if (DATA_W < 2 * IMM_W) begin : g_bad_width
         $error("ext_pipe: DATA_W must be at least 2*IMM_W");
      end
   endgenerate

   typedef enum logic {
      IDLE    = 1'b0,
      HI_HELD = 1'b1
   } state_t;

   state_t             state;
   logic [IMM_W-1:0]   hi_reg;

   logic               accept;
   logic               take;
   logic [DATA_W-1:0]  ext_word;
   logic [DATA_W-1:0]  cat_word;
   logic [DATA_W-1:0]  sign_word;

   assign in_ready = !rst && !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign take     = out_valid && out_ready;

   // Single-beat extension result for the IDLE state.
   always_comb begin
      sign_word = {{L{imm[IMM_W-1]}}, imm};
      ext_word  = {{L{1'b0}}, imm};
      case (ext_op)
         OP_SIGN: ext_word = sign_word;
         OP_HIGH: ext_word = {imm, {L{1'b0}}};
`ifdef EXT_SHL2_EN
         OP_SHL2: ext_word = sign_word << 2;
`endif
         default: ext_word = {{L{1'b0}}, imm};
      endcase
   end

   // Fused constant from the held upper half and the current immediate.
   // Built by slice assignment so DATA_W == 2*IMM_W needs no zero-width pad.
   always_comb begin
      cat_word                = '0;
      cat_word[2*IMM_W-1:0]   = {hi_reg, imm};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hi_reg    <= '0;
         cat_busy  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         // Any concurrent take is void; out_data keeps its last value.
         state     <= IDLE;
         cat_busy  <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         if (state == HI_HELD) begin
            // Low half: ext_op is ignored here.
            out_data  <= cat_word;
            out_valid <= 1'b1;
            state     <= IDLE;
            cat_busy  <= 1'b0;
         end else if (ext_op == OP_CAT) begin
            // Upper half only: nothing new for the output stage.
            hi_reg    <= imm;
            state     <= HI_HELD;
            cat_busy  <= 1'b1;
            if (take) begin
               out_valid <= 1'b0;
            end
         end else begin
            out_data  <= ext_word;
            out_valid <= 1'b1;
         end
      end else if (take) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

`ifdef EXT_SHL2_EN
   localparam int OP_W = 3;
`else
   localparam int OP_W = 2;
`endif

   localparam logic [OP_W-1:0] ZERO = OP_W'(0);
   localparam logic [OP_W-1:0] SIGN = OP_W'(1);
   localparam logic [OP_W-1:0] HIGH = OP_W'(2);
   localparam logic [OP_W-1:0] CAT  = OP_W'(3);

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [15:0]     imm;
   logic [OP_W-1:0] ext_op;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_data;
   logic            cat_busy;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .ext_op    (ext_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cat_busy  (cat_busy)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      imm       = 16'h0000;
      ext_op    = ZERO;
      out_ready = 1'b1;

      // Reset state
      #2;
      chk1 ("rst_in_ready",  in_ready,  1'b0);
      chk1 ("rst_out_valid", out_valid, 1'b0);
      chk1 ("rst_cat_busy",  cat_busy,  1'b0);
      chk32("rst_out_data",  out_data,  32'h0);
      tick;
      tick;
      rst = 1'b0;

      // SIGN 8001
      ext_op = SIGN; imm = 16'h8001; in_valid = 1'b1;
      #1 chk1("sign_in_ready", in_ready, 1'b1);
      tick;
      chk1 ("sign_valid", out_valid, 1'b1);
      chk32("sign_data",  out_data,  32'hFFFF8001);

      // ZERO then HIGH back-to-back
      ext_op = ZERO; imm = 16'h8001;
      #1 chk1("zero_in_ready", in_ready, 1'b1);
      tick;
      chk32("zero_data", out_data, 32'h00008001);
      ext_op = HIGH; imm = 16'h1234;
      #1 chk1("high_in_ready", in_ready, 1'b1);
      tick;
      chk32("high_data", out_data, 32'h12340000);
      chk1 ("high_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      tick;
      chk1("drain_valid", out_valid, 1'b0);

      // CAT DEAD, three idle cycles, then low half BEEF sent with SIGN
      ext_op = CAT; imm = 16'hDEAD; in_valid = 1'b1;
      tick;
      chk1("cat_hi_busy",  cat_busy,  1'b1);
      chk1("cat_hi_noout", out_valid, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk1("cat_idle_busy",  cat_busy,  1'b1);
         chk1("cat_idle_noout", out_valid, 1'b0);
      end
      ext_op = SIGN; imm = 16'hBEEF; in_valid = 1'b1;
      tick;
      chk1 ("cat_lo_valid", out_valid, 1'b1);
      chk32("cat_lo_data",  out_data,  32'hDEADBEEF);
      chk1 ("cat_lo_busy",  cat_busy,  1'b0);
      in_valid = 1'b0;
      tick;
      chk1("cat_single_out", out_valid, 1'b0);

      // Backpressure: word held 5 cycles while the next beat waits
      out_ready = 1'b0;
      ext_op = ZERO; imm = 16'h0042; in_valid = 1'b1;
      tick;
      chk1 ("bp_valid", out_valid, 1'b1);
      chk32("bp_data",  out_data,  32'h00000042);
      imm = 16'h0099;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk1("bp_in_ready", in_ready, 1'b0);
         tick;
         chk32("bp_stable", out_data,  32'h00000042);
         chk1 ("bp_held",   out_valid, 1'b1);
      end
      out_ready = 1'b1;
      #1 chk1("bp_release_ready", in_ready, 1'b1);
      tick;
      chk32("bp_next_data",  out_data,  32'h00000099);
      chk1 ("bp_next_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      tick;
      chk1("bp_drained", out_valid, 1'b0);

      // CAT AAAA then flush with a concurrent input beat
      ext_op = CAT; imm = 16'hAAAA; in_valid = 1'b1;
      tick;
      chk1("fl_hi_busy", cat_busy, 1'b1);
      flush = 1'b1; ext_op = ZERO; imm = 16'h1111;
      #1 chk1("fl_in_ready", in_ready, 1'b0);
      tick;
      chk1 ("fl_busy",  cat_busy,  1'b0);
      chk1 ("fl_valid", out_valid, 1'b0);
      chk32("fl_data_kept", out_data, 32'h00000099);
      flush = 1'b0; ext_op = ZERO; imm = 16'h0005;
      tick;
      chk1 ("fl_after_valid", out_valid, 1'b1);
      chk32("fl_after_data",  out_data,  32'h00000005);

      // Flush with a valid, stalled output word: dropped, data retained
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
      tick;
      chk1 ("fl_out_valid", out_valid, 1'b0);
      chk32("fl_out_data",  out_data,  32'h00000005);
      flush = 1'b0; out_ready = 1'b1;

`ifdef EXT_SHL2_EN
      in_valid = 1'b1; ext_op = OP_W'(4); imm = 16'hFFFF;
      tick;
      chk32("shl2_data", out_data, 32'hFFFFFFFC);
      ext_op = OP_W'(4); imm = 16'h4001;
      tick;
      chk32("shl2_trunc", out_data, 32'h00010004);
      ext_op = OP_W'(5); imm = 16'h8001;
      tick;
      chk32("op5_zero", out_data, 32'h00008001);
      ext_op = CAT; imm = 16'h1357;
      tick;
      ext_op = OP_W'(4); imm = 16'h8642;
      tick;
      chk32("shl2_in_cat", out_data, 32'h13578642);
      in_valid = 1'b0;
      tick;
`endif

      // Asynchronous reset while the upper half is held
      in_valid = 1'b1; ext_op = CAT; imm = 16'h1234;
      tick;
      chk1("rc_busy", cat_busy, 1'b1);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk1 ("rc_busy_clr",  cat_busy,  1'b0);
      chk1 ("rc_valid_clr", out_valid, 1'b0);
      chk32("rc_data_clr",  out_data,  32'h0);
      chk1 ("rc_in_ready",  in_ready,  1'b0);
      tick;
      rst = 1'b0;
      in_valid = 1'b1; ext_op = SIGN; imm = 16'h0001;
      tick;
      chk32("rc_no_partial", out_data, 32'h00000001);
      chk1 ("rc_idle",       cat_busy, 1'b0);
      in_valid = 1'b0;
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
